validator_core_mp: RTL
======================

// Module: validator_core_mp
// PURPOSE
// - Multi-mode, handshaked successor to the per-point outlier validator. Classifies one query point as inlier or outlier by
//   counting neighbours over LANES precomputed lane distances per cycle.
// - Sits between the distance-lane array (upstream, supplies one batch of LANES distances per beat) and the point writer.
// - Adds runtime mode/threshold selection, a start/ready/done handshake, partial-batch lane masks, early termination, a
//   saturating counter and abort.
// PARAMETERS
// N                  16  width of distances, radii, intensity
// LANES               8  distances consumed per beat
// CNT_W              16  neighbour-counter / threshold width
// SIZE_W             32  point-cloud-size / compared-counter width
// MIN_SEARCH_RADIUS   1  lower clamp of the dynamic radius
// ANG_SHIFT           3  dynamic radius = sensor_dist >> (ANG_SHIFT + i_multi_shift)
// PORTS
// i_clock          in   1         clock, all logic rising-edge
// i_reset_n        in   1         asynchronous active-low reset
// i_start          in   1         begin classification; sampled only in IDLE
// i_abort          in   1         synchronous abort to IDLE, any state
// i_mode           in   2         0 DROR, 1 ROR, 2 LIOR, 3 DLIOR (latched at start)
// i_sensor_dist    in   N         query-point distance to sensor (latched at start)
// i_point_i        in   N         query-point intensity (latched at start)
// i_intensity_thr  in   N         LIOR/DLIOR intensity bypass threshold
// i_fixed_radius   in   N         search radius for ROR/LIOR
// i_multi_shift    in   3         extra right-shift for DROR/DLIOR radius
// i_nbr_thr        in   CNT_W     neighbours needed for inlier
// i_cloud_size     in   SIZE_W    total comparisons before outlier verdict
// i_batch_valid    in   1         lane batch present
// i_lane_dist      in   N*LANES   lane distances, lane k at [k*N +: N]
// i_lane_mask      in   LANES     1 = lane k carries a real point
// o_ready          out  1         batch accepted on edge where i_batch_valid & o_ready
// o_busy           out  1         state != IDLE
// o_done           out  1         one-cycle pulse with verdict
// o_inlier         out  1         verdict, held until next accepted start
// o_outlier        out  1         verdict, held until next accepted start
// o_nbr_count      out  CNT_W     current neighbour count
// o_compared       out  SIZE_W    current comparisons counted
// BEHAVIOUR
// - Reset: state IDLE; every output 0; counters 0. i_abort: same as reset except o_inlier/o_outlier also cleared; no o_done.
// - States IDLE -> SETUP -> ACCUM -> DONE -> IDLE. o_inlier and o_outlier never both 1.
// - IDLE: i_start latches all config/point inputs, clears counters and verdict, -> SETUP. i_start ignored in other states.
// - SETUP (1 cycle): radius = i_fixed_radius for modes 1,2;
//   else max(MIN_SEARCH_RADIUS, sensor_dist >> (ANG_SHIFT+multi_shift)).
//   Priority: (mode 2|3 and point_i > intensity_thr) -> inlier; else nbr_thr==0 -> inlier; else cloud_size==0 -> outlier;
//   any of these -> DONE without consuming batches; otherwise -> ACCUM.
// - ACCUM: o_ready=1. On accepted beat: hits = popcount(mask & (dist<=radius)); nbr_count += hits, saturating at 2^CNT_W-1;
//   compared += popcount(mask), saturating at 2^SIZE_W-1. Inlier test (nbr_next >= nbr_thr) takes precedence over
//   outlier test (compared_next >= cloud_size). Either -> DONE with verdict registered. No beat -> stay, counters hold.
// - DONE (1 cycle): o_done=1, o_ready=0, -> IDLE. Verdict visible in the same cycle as o_done.
// - Latency: start accepted edge t -> SETUP at t+1 -> o_ready high from t+2; deciding beat at edge k -> o_done at k+1.
//   Intensity bypass: o_done at t+2.
// - Comparison is <= (distance equal to radius is a neighbour). Self-distance 0 is counted; exclusion is upstream's job.
// - Early termination: beats after the deciding beat are not accepted (o_ready low); upstream must hold or flush them.
// - Aborting with i_batch_valid high: that beat is not counted.
// TESTING
// - DROR, sensor_dist=800, shift=0, nbr_thr=3, beats mask=FF, 4 lanes<=100 -> radius 100, o_done+o_inlier one cycle after beat 1.
// - ROR, fixed_radius=50, cloud=20, all lanes 60: beats FF,FF,0F -> compared 20, o_outlier after 3rd beat; nbr_count 0.
// - LIOR, point_i=9, intensity_thr=4 -> o_inlier with o_done at t+2; o_ready never asserted.
// - DROR, sensor_dist=5 -> radius clamped 1; lane dist 1 counted, dist 2 not; nbr_thr=0 -> inlier in SETUP.
// - Last beat both reaches nbr_thr and cloud_size -> o_inlier=1, o_outlier=0.
// - i_abort in ACCUM with valid beat, then i_reset_n low mid-ACCUM -> IDLE, all outputs 0, no o_done; next start works.

Source files
------------

// File: rtl/validator_core_mp.sv
// Inlier/outlier classifier for one query point: counts neighbours over LANES lane
// distances per accepted beat, with mode-dependent radius and intensity bypass.
module validator_core_mp #(
  parameter int N                 = 16,
  parameter int LANES             = 8,
  parameter int CNT_W             = 16,
  parameter int SIZE_W            = 32,
  parameter int MIN_SEARCH_RADIUS = 1,
  parameter int ANG_SHIFT         = 3
) (
  input  logic                 i_clock,
  input  logic                 i_reset_n,
  input  logic                 i_start,
  input  logic                 i_abort,
  input  logic [1:0]           i_mode,
  input  logic [N-1:0]         i_sensor_dist,
  input  logic [N-1:0]         i_point_i,
  input  logic [N-1:0]         i_intensity_thr,
  input  logic [N-1:0]         i_fixed_radius,
  input  logic [2:0]           i_multi_shift,
  input  logic [CNT_W-1:0]     i_nbr_thr,
  input  logic [SIZE_W-1:0]    i_cloud_size,
  input  logic                 i_batch_valid,
  input  logic [N*LANES-1:0]   i_lane_dist,
  input  logic [LANES-1:0]     i_lane_mask,
  output logic                 o_ready,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_inlier,
  output logic                 o_outlier,
  output logic [CNT_W-1:0]     o_nbr_count,
  output logic [SIZE_W-1:0]    o_compared
);

  localparam int PC_W = $clog2(LANES + 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCUM, DONE} state_t;
  state_t state;

  logic [1:0]        mode_r;
  logic [N-1:0]      sensor_r, point_r, ithr_r, frad_r, radius_r;
  logic [2:0]        shift_r;
  logic [CNT_W-1:0]  nbr_thr_r;
  logic [SIZE_W-1:0] cloud_r;

  function automatic logic [PC_W-1:0] popcount(input logic [LANES-1:0] v);
    logic [PC_W-1:0] c;
    c = '0;
    for (int k = 0; k < LANES; k++) c = c + PC_W'(v[k]);
    return c;
  endfunction

  function automatic logic [CNT_W-1:0] sat_cnt(input logic [CNT_W:0] v);
    return v[CNT_W] ? '1 : v[CNT_W-1:0];
  endfunction

  function automatic logic [SIZE_W-1:0] sat_size(input logic [SIZE_W:0] v);
    return v[SIZE_W] ? '1 : v[SIZE_W-1:0];
  endfunction

  logic             start_ok, beat_ok, bypass;
  logic [LANES-1:0] hit_vec;
  logic [4:0]       shamt;
  logic [N-1:0]     shifted, radius_calc;
  logic [CNT_W-1:0] nbr_next;
  logic [SIZE_W-1:0] cmp_next;

  assign start_ok = (state == IDLE) && i_start && !i_abort;
  assign beat_ok  = (state == ACCUM) && i_batch_valid && !i_abort;
  assign o_ready  = (state == ACCUM);
  assign o_busy   = (state != IDLE);

  // Radius derived from latched point/config; only consumed while in SETUP.
  assign shamt       = 5'(ANG_SHIFT) + {2'b00, shift_r};
  assign shifted     = sensor_r >> shamt;
  assign radius_calc = (mode_r == 2'd1 || mode_r == 2'd2) ? frad_r :
                       (shifted < N'(MIN_SEARCH_RADIUS)) ? N'(MIN_SEARCH_RADIUS) : shifted;
  assign bypass      = mode_r[1] && (point_r > ithr_r);

  always_comb begin
    hit_vec = '0;
    for (int k = 0; k < LANES; k++)
      hit_vec[k] = i_lane_mask[k] && (i_lane_dist[k*N +: N] <= radius_r);
  end

  assign nbr_next = sat_cnt({1'b0, o_nbr_count} + (CNT_W+1)'(popcount(hit_vec)));
  assign cmp_next = sat_size({1'b0, o_compared} + (SIZE_W+1)'(popcount(i_lane_mask)));

  always_ff @(posedge i_clock) begin
    if (start_ok) begin
      mode_r    <= i_mode;
      sensor_r  <= i_sensor_dist;
      point_r   <= i_point_i;
      ithr_r    <= i_intensity_thr;
      frad_r    <= i_fixed_radius;
      shift_r   <= i_multi_shift;
      nbr_thr_r <= i_nbr_thr;
      cloud_r   <= i_cloud_size;
    end
    if (state == SETUP) radius_r <= radius_calc;
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state       <= IDLE;
      o_done      <= 1'b0;
      o_inlier    <= 1'b0;
      o_outlier   <= 1'b0;
      o_nbr_count <= '0;
      o_compared  <= '0;
    end else if (i_abort) begin
      state       <= IDLE;
      o_done      <= 1'b0;
      o_inlier    <= 1'b0;
      o_outlier   <= 1'b0;
      o_nbr_count <= '0;
      o_compared  <= '0;
    end else begin
      o_done <= 1'b0;
      case (state)
        IDLE: if (i_start) begin
          state       <= SETUP;
          o_inlier    <= 1'b0;
          o_outlier   <= 1'b0;
          o_nbr_count <= '0;
          o_compared  <= '0;
        end
        SETUP: begin
          // Bypass beats the zero-threshold check, which beats the empty-cloud check.
          if (bypass || nbr_thr_r == '0) begin
            state    <= DONE;
            o_done   <= 1'b1;
            o_inlier <= 1'b1;
          end else if (cloud_r == '0) begin
            state     <= DONE;
            o_done    <= 1'b1;
            o_outlier <= 1'b1;
          end else begin
            state <= ACCUM;
          end
        end
        ACCUM: if (beat_ok) begin
          o_nbr_count <= nbr_next;
          o_compared  <= cmp_next;
          if (nbr_next >= nbr_thr_r) begin
            state    <= DONE;
            o_done   <= 1'b1;
            o_inlier <= 1'b1;
          end else if (cmp_next >= cloud_r) begin
            state     <= DONE;
            o_done    <= 1'b1;
            o_outlier <= 1'b1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
